// File: rtl/mem_arb_pkg.sv
// Shared state encoding and grant codes for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// Memory latency watchdog: down-counter loaded on clear, expired at terminal count.
// After clear, expired is high during the TIMEOUT-th enabled cycle.
module arb_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= LOAD;
      end else if (enable && !expired) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between instruction fetch and data.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT data grants.
//
// state | meaning
// IDLE  | arbitrate; data has priority over fetch
// WAIT  | access in flight; waiting for mem_ready or watchdog expiry
// DONE  | ack pulse cycle, no arbitration
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int TIMEOUT      = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              grant_data,
   output logic              err
);

   arb_state_t        state, state_nxt;
   logic              pick_dm, wd_clear, wd_enable, wd_expired;
   logic              mem_req_nxt, mem_we_nxt, grant_data_nxt;
   logic              if_ack_nxt, dm_ack_nxt, err_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt, rdata_done;

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be at least 2");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_cnt;

   assign pick_dm = dm_req && !(if_req && (starve_cnt == STARVE_MAX));

   // Counts data grants that overtook a waiting fetch; cannot pass STARVE_MAX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         starve_cnt <= (pick_dm && if_req) ? starve_cnt + SW'(1) : '0;
      end
   end
`else
   assign pick_dm = dm_req;
`endif

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_sys (clk),
      .rst_b   (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      wd_clear       = 1'b0;
      wd_enable      = 1'b0;
      mem_req_nxt    = 1'b0;
      mem_we_nxt     = mem_we;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      grant_data_nxt = grant_data;
      if_ack_nxt     = 1'b0;
      dm_ack_nxt     = 1'b0;
      if_rdata_nxt   = if_rdata;
      dm_rdata_nxt   = dm_rdata;
      err_nxt        = err;
      // A watchdog completion returns zero data to the requester.
      rdata_done     = mem_ready ? mem_rdata : '0;
      unique case (state)
         IDLE: begin
            if (pick_dm) begin
               state_nxt      = WAIT;
               wd_clear       = 1'b1;
               mem_req_nxt    = 1'b1;
               mem_we_nxt     = dm_we;
               mem_addr_nxt   = dm_addr;
               mem_wdata_nxt  = dm_wdata;
               grant_data_nxt = GRANT_DM;
            end else if (if_req) begin
               state_nxt      = WAIT;
               wd_clear       = 1'b1;
               mem_req_nxt    = 1'b1;
               mem_we_nxt     = 1'b0;
               mem_addr_nxt   = if_addr;
               mem_wdata_nxt  = '0;
               grant_data_nxt = GRANT_IF;
            end
         end
         WAIT: begin
            if (mem_ready || wd_expired) begin
               state_nxt = DONE;
               err_nxt   = err | ~mem_ready;
               if (grant_data == GRANT_DM) begin
                  dm_ack_nxt = 1'b1;
                  if (!mem_we) dm_rdata_nxt = rdata_done;
               end else begin
                  if_ack_nxt   = 1'b1;
                  if_rdata_nxt = rdata_done;
               end
            end else begin
               mem_req_nxt = 1'b1;
               wd_enable   = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         grant_data <= 1'b0;
         if_ack     <= 1'b0;
         dm_ack     <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         err        <= 1'b0;
      end else begin
         mem_req    <= mem_req_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         grant_data <= grant_data_nxt;
         if_ack     <= if_ack_nxt;
         dm_ack     <= dm_ack_nxt;
         if_rdata   <= if_rdata_nxt;
         dm_rdata   <= dm_rdata_nxt;
         err        <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model with a word-addressed memory image.
module tb_mem_port_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int TIMEOUT      = 8;
   localparam int STARVE_LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk, rst;
   logic              if_req, if_ack;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req, dm_we, dm_ack;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata, dm_rdata;
   logic              mem_req, mem_we, mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              grant_data, err;

   int          vectors      = 0;
   int          miscompares  = 0;
   int          starve_run   = 0;
   logic        exp_err      = 1'b0;
   logic [31:0] exp_if_rdata = '0;
   logic [31:0] exp_dm_rdata = '0;
   logic [31:0] mem_model [logic [31:0]];

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant_data(grant_data), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: summary not reached within 200000 time units");
      $fatal(1, "bench time limit");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Called at a negedge with the DUT in IDLE and at least one request raised.
   // lat = WAIT cycle on which the memory answers; 0 = never (watchdog expiry).
   task automatic serve(input int lat);
      logic        exp_dm, w, to, fin;
      logic [31:0] a, wd, rd;
      exp_dm = dm_req && !(GUARD && if_req && (starve_run == STARVE_LIMIT));
      if (exp_dm) begin
         a = dm_addr; w = dm_we; wd = dm_wdata;
      end else begin
         a = if_addr; w = 1'b0; wd = '0;
      end
      starve_run = (exp_dm && if_req) ? starve_run + 1 : 0;
      rd  = mem_read(a);
      fin = 1'b0;
      @(negedge clk);
      for (int n = 1; n <= TIMEOUT && !fin; n++) begin
         chk1("wait_mem_req", mem_req, 1'b1);
         chk32("wait_mem_addr", mem_addr, a);
         chk1("wait_mem_we", mem_we, w);
         chk32("wait_mem_wdata", mem_wdata, wd);
         chk1("wait_grant_data", grant_data, exp_dm);
         chk1("wait_if_ack", if_ack, 1'b0);
         chk1("wait_dm_ack", dm_ack, 1'b0);
         if (n == 1 && $urandom_range(0, 3) == 0) begin
            if (exp_dm) dm_req = 1'b0;
            else        if_req = 1'b0;
         end
         if_addr   = rnd_addr();
         dm_addr   = rnd_addr();
         dm_wdata  = $urandom;
         dm_we     = 1'($urandom_range(0, 1));
         mem_ready = (n == lat);
         mem_rdata = (n == lat && !w) ? rd : $urandom;
         fin       = (n == lat);
         @(negedge clk);
      end
      to        = !fin;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!to && w) mem_model[a] = wd;
      if (!exp_dm)  exp_if_rdata = to ? '0 : rd;
      else if (!w)  exp_dm_rdata = to ? '0 : rd;
      if (to) exp_err = 1'b1;
      chk1("done_if_ack", if_ack, !exp_dm);
      chk1("done_dm_ack", dm_ack, exp_dm);
      chk1("done_mem_req", mem_req, 1'b0);
      chk32("done_if_rdata", if_rdata, exp_if_rdata);
      chk32("done_dm_rdata", dm_rdata, exp_dm_rdata);
      chk1("done_err", err, exp_err);
      if (exp_dm) dm_req = 1'b0;
      else        if_req = 1'b0;
      @(negedge clk);
      chk1("idle_if_ack", if_ack, 1'b0);
      chk1("idle_dm_ack", dm_ack, 1'b0);
      chk1("idle_mem_req", mem_req, 1'b0);
      chk1("idle_grant_data", grant_data, exp_dm);
      chk32("idle_if_rdata", if_rdata, exp_if_rdata);
      chk32("idle_dm_rdata", dm_rdata, exp_dm_rdata);
   endtask

   task automatic idle_gap(input int n);
      if_req     = 1'b0;
      dm_req     = 1'b0;
      starve_run = 0;
      repeat (n) begin
         @(negedge clk);
         chk1("gap_mem_req", mem_req, 1'b0);
         chk1("gap_if_ack", if_ack, 1'b0);
         chk1("gap_dm_ack", dm_ack, 1'b0);
      end
   endtask

   initial begin
      logic [9:0] order;
      rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0; order = '0;
      #3;
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_dm_ack", dm_ack, 1'b0);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_grant_data", grant_data, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk32("rst_if_rdata", if_rdata, '0);
      chk32("rst_dm_rdata", dm_rdata, '0);
      chk32("rst_mem_addr", mem_addr, '0);
      chk32("rst_mem_wdata", mem_wdata, '0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // single fetch answered on the first WAIT cycle
      mem_model[32'h10] = 32'hDEAD_BEEF;
      if_req = 1'b1; if_addr = 32'h10;
      serve(1);
      chk32("fetch_if_rdata", if_rdata, 32'hDEAD_BEEF);

      // collision: data write first, then fetch
      if_req = 1'b1; if_addr = 32'h20;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h5;
      serve(1);
      chk1("collision_first_grant", grant_data, 1'b1);
      chk32("collision_dm_rdata", dm_rdata, '0);
      serve(1);
      chk1("collision_second_grant", grant_data, 1'b0);

      // data read with three wait cycles
      mem_model[32'h80] = 32'h1234;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      serve(3);
      chk32("wait_states_dm_rdata", dm_rdata, 32'h1234);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         if (!dm_req) begin
            dm_req   = 1'($urandom_range(0, 1));
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = rnd_addr();
            dm_wdata = $urandom;
         end
         if (!if_req) begin
            if_req  = 1'($urandom_range(0, 1));
            if_addr = rnd_addr();
         end
         if (!dm_req && !if_req) if_req = 1'b1;
         serve($urandom_range(1, TIMEOUT));
      end

      // watchdog expiry on a fetch, then err stays set
      idle_gap(1);
      if_req = 1'b1; if_addr = 32'h44;
      serve(0);
      chk1("timeout_err", err, 1'b1);
      chk32("timeout_if_rdata", if_rdata, '0);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = rnd_addr();
      serve(2);
      chk1("err_sticky", err, 1'b1);

      // reset in the middle of an access
      if_req = 1'b1; if_addr = 32'h30;
      @(negedge clk);
      chk1("pre_rst_mem_req", mem_req, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk1("rst_wait_mem_req", mem_req, 1'b0);
      chk1("rst_wait_if_ack", if_ack, 1'b0);
      chk1("rst_wait_err", err, 1'b0);
      chk32("rst_wait_if_rdata", if_rdata, '0);
      chk32("rst_wait_dm_rdata", dm_rdata, '0);
      if_req = 1'b0;
      exp_err = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0; starve_run = 0;
      @(negedge clk);
      rst = 1'b1;
      idle_gap(3);
      if_req = 1'b1; if_addr = 32'h30;
      serve(1);
      chk1("post_rst_err", err, 1'b0);

      // both requesters held high: grant order
      idle_gap(2);
      for (int i = 0; i < 10; i++) begin
         dm_req = 1'b1;
         if_req = 1'b1;
         serve($urandom_range(1, 3));
         order[i] = grant_data;
      end
      chk32("starve_order", {22'd0, order}, GUARD ? 32'h0000_01EF : 32'h0000_03FF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
